// File: rtl/me_sprite_addr_gen_if.sv
// Scan-position / animation-control bundle between the player logic and the sprite
// address generator. The master drives scan, position and control; the slave returns ROM selectors.
interface me_sprite_addr_gen_if;
    logic        frame_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  PosX;
    logic [9:0]  PosY;
    logic        walk;
    logic        attack;
    logic        facing_left;
    logic [7:0]  state;
    logic [15:0] relative_address;
    logic        in_sprite_q;
    logic        busy;

    modport master (
        output frame_clk, DrawX, DrawY, PosX, PosY, walk, attack, facing_left,
        input  state, relative_address, in_sprite_q, busy
    );

    modport slave (
        input  frame_clk, DrawX, DrawY, PosX, PosY, walk, attack, facing_left,
        output state, relative_address, in_sprite_q, busy
    );
endinterface

// File: rtl/me_sprite_addr_gen.sv
// Player animation FSM plus registered sprite ROM address / pixel-valid generation.
// Optional horizontal mirroring is compiled in with `define ME_FLIP_EN.
module me_sprite_addr_gen #(
    parameter int W_IDLE    = 100,
    parameter int W_ATK     = 120,
    parameter int H         = 100,
    parameter int WALK_HOLD = 8,
    parameter int ATK_HOLD  = 4
) (
    input logic                 Clk,
    input logic                 Reset,
    me_sprite_addr_gen_if.slave bus
);

    localparam int MAX_HOLD = (WALK_HOLD > ATK_HOLD) ? WALK_HOLD : ATK_HOLD;
    localparam int CW       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WALK_A,
        S_WALK_B,
        S_ATK0,
        S_ATK1,
        S_ATK2,
        S_REC0,
        S_REC1
    } anim_e;

    anim_e          cur_state;
    anim_e          nxt_state;
    logic [CW-1:0]  hold_cnt;
    logic [CW-1:0]  hold_nxt;
    logic           walk_done;
    logic           atk_done;

    logic           fc_q;
    logic           fc_armed;
    logic           tick;

    logic [7:0]     code;
    logic [15:0]    w;
    logic           busy_c;

    logic [10:0]    dx;
    logic [10:0]    dy;
    logic [15:0]    col;
    logic           hit;
    logic [15:0]    addr;

    logic [15:0]    addr_q;
    logic           hit_q;
    logic           in_sprite_qq;

    // ---------------- frame tick edge detect ----------------
    // fc_armed stays low until frame_clk has been seen low, so a level that is already high
    // when reset releases does not count as a rising edge.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            fc_q     <= 1'b0;
            fc_armed <= ~bus.frame_clk;
        end else begin
            fc_q <= bus.frame_clk;
            if (!bus.frame_clk)
                fc_armed <= 1'b1;
        end
    end

    assign tick = bus.frame_clk & ~fc_q & fc_armed;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur_state <= S_IDLE;
            hold_cnt  <= '0;
        end else if (tick) begin
            cur_state <= nxt_state;
            hold_cnt  <= hold_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    assign walk_done = (hold_cnt == CW'(WALK_HOLD - 1));
    assign atk_done  = (hold_cnt == CW'(ATK_HOLD - 1));

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: begin
                if (bus.attack)
                    nxt_state = S_ATK0;
                else if (bus.walk)
                    nxt_state = S_WALK_A;
            end
            S_WALK_A, S_WALK_B: begin
                if (bus.attack)
                    nxt_state = S_ATK0;
                else if (!bus.walk)
                    nxt_state = S_IDLE;
                else if (walk_done)
                    nxt_state = (cur_state == S_WALK_A) ? S_WALK_B : S_WALK_A;
            end
            S_ATK0:  if (atk_done) nxt_state = S_ATK1;
            S_ATK1:  if (atk_done) nxt_state = S_ATK2;
            S_ATK2:  if (atk_done) nxt_state = S_REC0;
            S_REC0:  if (atk_done) nxt_state = S_REC1;
            S_REC1:  if (atk_done) nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase

        // Hold count restarts on every entry; idle never needs it.
        if (nxt_state != cur_state || cur_state == S_IDLE)
            hold_nxt = '0;
        else
            hold_nxt = hold_cnt + 1'b1;
    end

    // ---------------- FSM: outputs ----------------
    // Code and width both decode the same state register, so they always switch together.
    always_comb begin
        code   = 8'h01;
        w      = 16'(W_IDLE);
        busy_c = 1'b0;
        case (cur_state)
            S_IDLE:   code = 8'h01;
            S_WALK_A: code = 8'h01;
            S_WALK_B: code = 8'h02;
            S_ATK0:   begin code = 8'h06; w = 16'(W_ATK); busy_c = 1'b1; end
            S_ATK1:   begin code = 8'h07; w = 16'(W_ATK); busy_c = 1'b1; end
            S_ATK2:   begin code = 8'h09; w = 16'(W_ATK); busy_c = 1'b1; end
            S_REC0:   begin code = 8'h05; w = 16'(W_ATK); busy_c = 1'b1; end
            S_REC1:   begin code = 8'h08; w = 16'(W_ATK); busy_c = 1'b1; end
            default:  code = 8'h01;
        endcase
    end

    assign bus.state = code;
    assign bus.busy  = busy_c;

    // ---------------- address arithmetic ----------------
    // Bit 10 of the 11-bit difference is the sign, so positions left of / above the sprite never wrap.
    assign dx  = {1'b0, bus.DrawX} - {1'b0, bus.PosX};
    assign dy  = {1'b0, bus.DrawY} - {1'b0, bus.PosY};
    assign hit = ~dx[10] && ({5'b0, dx} < w) && ~dy[10] && ({5'b0, dy} < 16'(H));

`ifdef ME_FLIP_EN
    assign col = bus.facing_left ? (w - 16'd1 - {5'b0, dx}) : {5'b0, dx};
`else
    logic unused_facing_left;
    assign unused_facing_left = bus.facing_left;
    assign col                = {5'b0, dx};
`endif

    assign addr = hit ? ({5'b0, dy} * w + col) : 16'd0;

    // Two hit stages: one aligns with addr_q, one with the ROM's own output register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q       <= 16'd0;
            hit_q        <= 1'b0;
            in_sprite_qq <= 1'b0;
        end else begin
            addr_q       <= addr;
            hit_q        <= hit;
            in_sprite_qq <= hit_q;
        end
    end

    assign bus.relative_address = addr_q;
    assign bus.in_sprite_q      = in_sprite_qq;

endmodule

// File: tb/tb_me_sprite_addr_gen.sv
// Directed plus randomized bench for me_sprite_addr_gen; expected values come from
// plain arithmetic on the animation timeline and sprite geometry.
module tb_me_sprite_addr_gen;

    localparam int W_IDLE    = 100;
    localparam int W_ATK     = 120;
    localparam int H         = 100;
    localparam int WALK_HOLD = 8;
    localparam int ATK_HOLD  = 4;

    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    me_sprite_addr_gen_if bus ();

    me_sprite_addr_gen #(
        .W_IDLE   (W_IDLE),
        .W_ATK    (W_ATK),
        .H        (H),
        .WALK_HOLD(WALK_HOLD),
        .ATK_HOLD (ATK_HOLD)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_tick();
        bus.frame_clk = 1'b1;
        step();
        bus.frame_clk = 1'b0;
        step();
    endtask

    // Expected code k ticks after walking starts from idle (k >= 1).
    function automatic int walk_code(input int k);
        return (((k - 1) / WALK_HOLD) % 2) ? 8'h02 : 8'h01;
    endfunction

    // Expected code k ticks after the attack starts (k = 1 is the tick that enters it).
    function automatic int atk_code(input int k);
        if (k < 1 || k > 5 * ATK_HOLD) return 8'h01;
        case ((k - 1) / ATK_HOLD)
            0:       return 8'h06;
            1:       return 8'h07;
            2:       return 8'h09;
            3:       return 8'h05;
            default: return 8'h08;
        endcase
    endfunction

    // Present one pixel, check the address one cycle later and the valid flag one cycle after that.
    task automatic px(input string tag, input int pxv, input int pyv, input int dxv, input int dyv,
                      input bit fl, input int exp_addr, input bit exp_hit);
        bus.PosX        = 10'(pxv);
        bus.PosY        = 10'(pyv);
        bus.DrawX       = 10'(dxv);
        bus.DrawY       = 10'(dyv);
        bus.facing_left = fl;
        step();
        chk({tag, ".addr"}, bus.relative_address, exp_addr);
        step();
        chk({tag, ".in_sprite"}, bus.in_sprite_q, exp_hit);
    endtask

    task automatic rand_px(input string tag, input int w);
        int  pxv, pyv, dxv, dyv, ddx, ddy, col, ea;
        bit  fl, eh;
        pxv = $urandom_range(0, 639);
        pyv = $urandom_range(0, 479);
        dxv = pxv + $urandom_range(0, w + 40) - 20;
        dyv = pyv + $urandom_range(0, H + 40) - 20;
        if (dxv < 0) dxv = 0;
        if (dxv > 1023) dxv = 1023;
        if (dyv < 0) dyv = 0;
        if (dyv > 1023) dyv = 1023;
        fl  = 1'($urandom_range(0, 1));
        ddx = dxv - pxv;
        ddy = dyv - pyv;
        eh  = (ddx >= 0) && (ddx < w) && (ddy >= 0) && (ddy < H);
        col = ddx;
`ifdef ME_FLIP_EN
        if (fl) col = w - 1 - ddx;
`endif
        ea = eh ? (ddy * w + col) : 0;
        px(tag, pxv, pyv, dxv, dyv, fl, ea, eh);
    endtask

    initial begin
        int busy_ticks;

        Reset           = 1'b1;
        bus.frame_clk   = 1'b0;
        bus.DrawX       = '0;
        bus.DrawY       = '0;
        bus.PosX        = '0;
        bus.PosY        = '0;
        bus.walk        = 1'b0;
        bus.attack      = 1'b0;
        bus.facing_left = 1'b0;
        step();
        step();
        chk("rst.state", bus.state, 8'h01);
        chk("rst.addr", bus.relative_address, 0);
        chk("rst.in_sprite", bus.in_sprite_q, 0);
        chk("rst.busy", bus.busy, 0);
        Reset = 1'b0;

        // Idle geometry, width 100.
        px("idle_basic", 100, 50, 105, 52, 1'b0, 205, 1'b1);
        chk("idle_basic.state", bus.state, 8'h01);
        px("left_edge", 100, 50, 99, 52, 1'b0, 0, 1'b0);
        px("right_edge", 100, 50, 200, 52, 1'b0, 0, 1'b0);
        px("last_pixel", 100, 50, 199, 149, 1'b0, 9999, 1'b1);
        px("below", 100, 50, 150, 150, 1'b0, 0, 1'b0);
        px("no_wrap", 1000, 50, 10, 50, 1'b0, 0, 1'b0);
        px("offscreen_part", 600, 50, 639, 149, 1'b0, 9939, 1'b1);
        px("atk_width_idle", 0, 0, 119, 1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 30; i++) rand_px("rand_idle", W_IDLE);
        bus.facing_left = 1'b0;

        // Walk cycle.
        bus.walk = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            do_tick();
            chk("walk.state", bus.state, walk_code(k));
        end
        bus.walk = 1'b0;
        do_tick();
        chk("walk_stop.state", bus.state, 8'h01);
        chk("walk_stop.busy", bus.busy, 0);

        // Single attack pulse; walk raised mid-chain must be ignored.
        busy_ticks = 0;
        bus.attack = 1'b1;
        for (int k = 1; k <= 5 * ATK_HOLD + 1; k++) begin
            do_tick();
            bus.attack = 1'b0;
            bus.walk   = 1'b1;
            chk("atk.state", bus.state, atk_code(k));
            busy_ticks += int'(bus.busy);
            if (k == ATK_HOLD + 2) begin
                px("atk1_width", 0, 0, 119, 1, 1'b0, 239, 1'b1);
                px("atk1_edge", 0, 0, 120, 1, 1'b0, 0, 1'b0);
                for (int i = 0; i < 12; i++) rand_px("rand_atk", W_ATK);
                bus.facing_left = 1'b0;
            end
        end
        chk("atk.busy_ticks", busy_ticks, 5 * ATK_HOLD);
        chk("atk_end.busy", bus.busy, 0);
        bus.walk = 1'b0;

        // Held attack: chain completes to idle, then re-enters on the following tick.
        bus.attack = 1'b1;
        for (int k = 1; k <= 5 * ATK_HOLD + 1; k++) begin
            do_tick();
            chk("held.state", bus.state, atk_code(k));
        end
        do_tick();
        chk("held_reenter.state", bus.state, 8'h06);
        for (int k = 2; k <= 2 * ATK_HOLD + 1; k++) do_tick();
        chk("held_atk2.state", bus.state, 8'h09);
        px("pre_reset_hit", 0, 0, 10, 10, 1'b0, 1210, 1'b1);

        // Reset mid-attack.
        Reset = 1'b1;
        step();
        chk("mid_rst.state", bus.state, 8'h01);
        chk("mid_rst.busy", bus.busy, 0);
        chk("mid_rst.in_sprite", bus.in_sprite_q, 0);
        bus.attack = 1'b0;
        Reset      = 1'b0;
        step();

        // Walk and attack together from idle: attack wins.
        bus.walk   = 1'b1;
        bus.attack = 1'b1;
        do_tick();
        chk("both.state", bus.state, 8'h06);
        chk("both.busy", bus.busy, 1);
        bus.walk   = 1'b0;
        bus.attack = 1'b0;
        Reset      = 1'b1;
        step();
        Reset = 1'b0;
        step();

        // frame_clk held high yields exactly one tick.
        bus.attack    = 1'b1;
        bus.frame_clk = 1'b1;
        step();
        bus.attack = 1'b0;
        chk("level_first.state", bus.state, 8'h06);
        for (int i = 0; i < 12; i++) step();
        chk("level_hold.state", bus.state, 8'h06);
        bus.frame_clk = 1'b0;
        step();

        // frame_clk already high at reset release does not tick.
        Reset         = 1'b1;
        bus.frame_clk = 1'b1;
        bus.attack    = 1'b1;
        step();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rel_high.state", bus.state, 8'h01);
        bus.frame_clk = 1'b0;
        step();
        do_tick();
        chk("rel_next_edge.state", bus.state, 8'h06);
        bus.attack = 1'b0;

`ifdef ME_FLIP_EN
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        px("flip_origin", 0, 0, 0, 0, 1'b1, 99, 1'b1);
        px("flip_last", 0, 0, 99, 99, 1'b1, 9900, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
